// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: shared state encodings and default width for the serial adder
package bit_serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/fadder_df.sv
// fadder_df: dataflow one-bit full adder
module fadder_df (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic z
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first bit-serial adder, one full-adder step per clock
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_p_next;

    fadder_df u_fa (
        .s (w_s),
        .c (w_c),
        .x (r_a[0]),
        .y (r_b[0]),
        .z (r_carry)
    );

    assign w_p_next = {w_s, r_p[WIDTH-1:1]};

    // Control FSM with operand shifting, partial-sum build-up and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_carry <= cin;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_p     <= w_p_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_p_next;
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule
